// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM states and default width.
package serial_arith_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor: start/busy/done handshake plus operands.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, bout
  );
endinterface

// File: rtl/serial_subtractor_fs.sv
// Combinational 1-bit full subtractor cell: {bout, diff} = a - b - bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, single borrow flip-flop.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic w_diff;
  logic w_bout;
  logic w_last;
  logic w_load;
  logic w_step;
  logic w_busy;
  logic w_done;

  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_brw),
    .diff (w_diff),
    .bout (w_bout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH steps the first bit sits at bit 0;
  // d/bout are only written on the final step so partial results stay hidden.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_a   <= bus.a;
      r_b   <= bus.b;
      r_brw <= bus.bin;
      r_cnt <= '0;
    end else if (w_step) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_brw <= w_bout;
      r_res <= {w_diff, r_res[WIDTH-1:1]};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_d    <= {w_diff, r_res[WIDTH-1:1]};
        r_bout <= w_bout;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.d    = r_d;
  assign bus.bout = r_bout;

endmodule
